jv1_sector_buf: RTL and testbench

- Sits between the hps_io virtual-disk channel (sd_* / img_*) and the TRS-80 FDC core.
- Translates a JV1 track/sector request on one of up to 4 mounted DSKJV1 images into a 512-byte SD block access.
- Holds the block in a local buffer and exposes the addressed 256-byte sector half to the FDC for byte-wise read/write.
- On commit, writes the whole 512-byte block back to the image.

---
 rtl/jv1_pkg.sv | 22 ++
 rtl/dpram_512x8.sv | 34 +++
 rtl/jv1_sector_buf.sv | 230 +++++++++++++++++++++++
 tb/tb_jv1_sector_buf.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jv1_pkg.sv
// Shared types for the JV1 sector buffer: result codes, FSM states, sizes.
// Exports ERR_* codes, state_t and SECT_BYTES.
package jv1_pkg;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_RNF = 2'd1;
    localparam logic [1:0] ERR_WP  = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam int SECT_BYTES = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_REQ,
        S_RD_XFER,
        S_WR_REQ,
        S_WR_XFER,
        S_DONE
    } state_t;

endpackage

// File: rtl/dpram_512x8.sv
// 512x8 dual-port block buffer; port A serves the FDC, port B serves hps_io.
// Ports: clk, rst_n, a_addr/a_din/a_we/a_dout, b_addr/b_din/b_we/b_dout.
module dpram_512x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] a_addr,
    input  logic [7:0] a_din,
    input  logic       a_we,
    output logic [7:0] a_dout,
    input  logic [8:0] b_addr,
    input  logic [7:0] b_din,
    input  logic       b_we,
    output logic [7:0] b_dout
);

    logic [7:0] mem [512];

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_din;
        if (b_we) mem[b_addr] <= b_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout <= '0;
            b_dout <= '0;
        end else begin
            a_dout <= mem[a_addr];
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/jv1_sector_buf.sv
// JV1 track/sector to 512-byte SD block bridge between hps_io and the FDC.
// Ports: mount info in, FDC request/byte port, sd_* block handshake to hps_io.
module jv1_sector_buf
    import jv1_pkg::*;
#(
    parameter int          NBDRIV  = 4,
    parameter int          SPT     = 10,
    parameter logic [23:0] TIMEOUT = 24'd4200000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [NBDRIV-1:0] img_mounted,
    input  logic [31:0]       img_size,
    input  logic              img_readonly,
    input  logic [1:0]        drv,
    input  logic [6:0]        track,
    input  logic [3:0]        sector,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [NBDRIV-1:0] wp,
    input  logic [7:0]        buf_addr,
    input  logic [7:0]        buf_din,
    input  logic              buf_we,
    output logic [7:0]        buf_dout,
    output logic [31:0]       sd_lba,
    output logic [NBDRIV-1:0] sd_rd,
    output logic [NBDRIV-1:0] sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    output logic [7:0]        sd_buff_din,
    input  logic              sd_buff_wr
);

    state_t state, state_nxt;

    logic [NBDRIV-1:0] mnt_q, mnt_rise, wp_q, sel;
    logic [31:0]       size_q [NBDRIV];

    logic [1:0]  drv_q, err_q, err_nxt;
    logic [10:0] lin, lin_q;
    logic        wr_q, sbad_q;
    logic [23:0] tmo_cnt;
    logic        tmo_hit;

    logic        cvalid, hit;
    logic [1:0]  cdrv;
    logic [9:0]  clba;

    logic [31:0] sz, need;
    logic        wpd, nf;
    logic        a_we, b_we;

    assign lin      = 11'(32'(track) * 32'(SPT) + 32'(sector));
    assign mnt_rise = img_mounted & ~mnt_q;
    assign tmo_hit  = (tmo_cnt == TIMEOUT - 24'd1);
    assign need     = (32'(lin_q) + 32'd1) << 8;
    assign hit      = cvalid && (cdrv == drv_q) && (clba == lin_q[10:1]);
    assign nf       = sbad_q || (sz == '0) || (need > sz);
    assign sel      = NBDRIV'(1) << drv_q;

    always_comb begin
        sz  = '0;
        wpd = 1'b0;
        for (int i = 0; i < NBDRIV; i++) begin
            if (drv_q == 2'(i)) begin
                sz  = size_q[i];
                wpd = wp_q[i];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mnt_q <= '0;
            wp_q  <= '0;
            for (int i = 0; i < NBDRIV; i++) size_q[i] <= '0;
        end else begin
            mnt_q <= img_mounted;
            for (int i = 0; i < NBDRIV; i++) begin
                if (mnt_rise[i]) begin
                    size_q[i] <= img_size;
                    wp_q[i]   <= img_readonly;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        unique case (state)
            S_IDLE: begin
                if (rd_req || wr_req) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (nf) begin
                    err_nxt   = ERR_RNF;
                    state_nxt = S_DONE;
                end else if (wr_q && wpd) begin
                    err_nxt   = ERR_WP;
                    state_nxt = S_DONE;
                end else if (wr_q && hit) begin
                    state_nxt = S_WR_REQ;
                end else begin
                    state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (sd_ack) begin
                    state_nxt = S_RD_XFER;
                end else if (tmo_hit) begin
                    err_nxt   = ERR_TMO;
                    state_nxt = S_DONE;
                end
            end
            // A write to an uncached block reads it first, then commits.
            S_RD_XFER: begin
                if (!sd_ack) begin
                    if (wr_q) begin
                        state_nxt = S_WR_REQ;
                    end else begin
                        err_nxt   = ERR_OK;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WR_REQ: begin
                if (sd_ack) begin
                    state_nxt = S_WR_XFER;
                end else if (tmo_hit) begin
                    err_nxt   = ERR_TMO;
                    state_nxt = S_DONE;
                end
            end
            S_WR_XFER: begin
                if (!sd_ack) begin
                    err_nxt   = ERR_OK;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            drv_q   <= '0;
            lin_q   <= '0;
            wr_q    <= 1'b0;
            sbad_q  <= 1'b0;
            err_q   <= ERR_OK;
            tmo_cnt <= '0;
        end else begin
            err_q <= err_nxt;
            if (state == S_IDLE && (rd_req || wr_req)) begin
                drv_q  <= drv;
                lin_q  <= lin;
                wr_q   <= wr_req;
                sbad_q <= 32'(sector) >= 32'(SPT);
            end
            if ((state == S_RD_REQ || state == S_WR_REQ) && !sd_ack)
                tmo_cnt <= tmo_cnt + 24'd1;
            else
                tmo_cnt <= '0;
        end
    end

    // The cache tag is dropped as soon as a block read starts and is only
    // restored once the whole block has streamed in.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cvalid <= 1'b0;
            cdrv   <= '0;
            clba   <= '0;
        end else begin
            if (state == S_RD_REQ) cvalid <= 1'b0;
            if (state == S_RD_XFER && !sd_ack) begin
                cvalid <= 1'b1;
                cdrv   <= drv_q;
                clba   <= lin_q[10:1];
            end
            for (int i = 0; i < NBDRIV; i++) begin
                if (mnt_rise[i] && cdrv == 2'(i)) cvalid <= 1'b0;
            end
        end
    end

    // On the read-before-write path the addressed half holds FDC edits,
    // so only the other half is refilled from the image.
    assign b_we = sd_ack && sd_buff_wr
               && (state == S_RD_REQ || state == S_RD_XFER)
               && !(wr_q && sd_buff_addr[8] == lin_q[0]);
    assign a_we = buf_we && (state == S_IDLE) && !b_we;

    dpram_512x8 u_buf (
        .clk    (clk_sys),
        .rst_n  (reset_n),
        .a_addr ({lin_q[0], buf_addr}),
        .a_din  (buf_din),
        .a_we   (a_we),
        .a_dout (buf_dout),
        .b_addr (sd_buff_addr),
        .b_din  (sd_buff_dout),
        .b_we   (b_we),
        .b_dout (sd_buff_din)
    );

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign err    = err_q;
    assign wp     = wp_q;
    assign sd_lba = {21'b0, lin_q[10:1]};
    assign sd_rd  = (state == S_RD_REQ) ? sel : '0;
    assign sd_wr  = (state == S_WR_REQ) ? sel : '0;

endmodule

// File: tb/tb_jv1_sector_buf.sv
// Scoreboard bench for jv1_sector_buf with an hps_io host model.
// Ports: none; drives the DUT and reports one summary line.
module tb_jv1_sector_buf;

    localparam logic [23:0] TMO = 24'd300;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  img_mounted = '0;
    logic [31:0] img_size = '0;
    logic        img_readonly = 1'b0;
    logic [1:0]  drv = '0;
    logic [6:0]  track = '0;
    logic [3:0]  sector = '0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic        busy, done;
    logic [1:0]  err;
    logic [3:0]  wp;
    logic [7:0]  buf_addr = '0;
    logic [7:0]  buf_din = '0;
    logic        buf_we = 1'b0;
    logic [7:0]  buf_dout;
    logic [31:0] sd_lba;
    logic [3:0]  sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = '0;
    logic [7:0]  sd_buff_dout = '0;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr = 1'b0;

    always #5 clk_sys = ~clk_sys;

    jv1_sector_buf #(.NBDRIV(4), .SPT(10), .TIMEOUT(TMO)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .drv          (drv),
        .track        (track),
        .sector       (sector),
        .rd_req       (rd_req),
        .wr_req       (wr_req),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .wp           (wp),
        .buf_addr     (buf_addr),
        .buf_din      (buf_din),
        .buf_we       (buf_we),
        .buf_dout     (buf_dout),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit        wr;
        bit [1:0]  drv;
        bit [31:0] lba;
    } sdreq_t;

    sdreq_t     exp_sd[$];
    logic [1:0] exp_err[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_wr[$];

    // Reference model: image geometry per drive and the 512-byte block buffer.
    int         msize [4];
    bit         mwp [4];
    bit         m_valid;
    int         m_drv, m_lba, m_half;
    logic [7:0] m_buf [512];
    logic [7:0] salt;
    bit         ack_en = 1'b1;
    int         sd_cnt = 0;
    logic       fdc_rd_s = 1'b0;
    logic       rd_pend = 1'b0;

    always @(negedge clk_sys)
        if (sd_rd != 0 || sd_wr != 0) sd_cnt++;

    always @(negedge clk_sys) begin
        if (done) begin
            if (exp_err.size() == 0) chk("done_unexpected", {62'd0, err}, 64'd9);
            else chk("done_err", {62'd0, err}, {62'd0, exp_err.pop_front()});
        end
    end

    always @(posedge clk_sys) rd_pend <= fdc_rd_s;

    always @(negedge clk_sys) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) chk("fdc_rd_unexpected", {56'd0, buf_dout}, 64'h1ff);
            else chk("fdc_rd", {56'd0, buf_dout}, {56'd0, exp_rd.pop_front()});
        end
    end

    task automatic host_xfer();
        bit         is_wr, known, abort;
        logic [3:0] got;
        sdreq_t     e;
        logic [7:0] cap [512];
        logic [7:0] ew [512];
        int         nbad;
        is_wr = (sd_wr != 0);
        got   = is_wr ? sd_wr : sd_rd;
        known = 1'b0;
        abort = 1'b0;
        if (exp_sd.size() == 0) begin
            chk("sd_req_unexpected", {59'd0, is_wr, got}, 64'd0);
        end else begin
            e = exp_sd.pop_front();
            known = 1'b1;
            chk("sd_req", {27'd0, is_wr, got, sd_lba},
                {27'd0, e.wr, 4'(4'd1 << e.drv), e.lba});
        end
        if (is_wr && known && e.wr && exp_wr.size() >= 512)
            for (int i = 0; i < 512; i++) ew[i] = exp_wr.pop_front();
        else
            known = 1'b0;
        for (int k = 0; k <= 512; k++) begin
            @(posedge clk_sys);
            #1;
            if (!reset_n) begin
                abort = 1'b1;
                break;
            end
            sd_ack = 1'b1;
            if (k < 512) sd_buff_addr = 9'(k);
            sd_buff_wr   = !is_wr && (k < 512);
            sd_buff_dout = 8'(k) ^ salt;
            @(negedge clk_sys);
            if (!reset_n) begin
                abort = 1'b1;
                break;
            end
            if (is_wr && k >= 1) cap[k-1] = sd_buff_din;
        end
        if (!abort) begin
            @(posedge clk_sys);
            #1;
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        if (is_wr && known && !abort) begin
            nbad = 0;
            for (int i = 0; i < 512; i++)
                if (cap[i] !== ew[i]) nbad++;
            chk("wr_block_bad_bytes", 64'(nbad), 64'd0);
        end
    endtask

    initial begin : host
        forever begin
            @(negedge clk_sys);
            if (reset_n && ack_en && (sd_rd != 0 || sd_wr != 0)) host_xfer();
        end
    end

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        forever begin
            @(negedge clk_sys);
            if (!busy) break;
            n++;
            if (n > budget) begin
                chk("busy_budget", {63'd0, busy}, 64'd0);
                break;
            end
        end
    endtask

    task automatic mount(input int d, input int sz, input bit ro);
        logic [3:0] mw;
        @(posedge clk_sys);
        #1;
        img_size       = sz;
        img_readonly   = ro;
        img_mounted[d] = 1'b1;
        @(posedge clk_sys);
        #1;
        img_mounted = '0;
        msize[d] = sz;
        mwp[d]   = ro;
        if (m_drv == d) m_valid = 1'b0;
        for (int i = 0; i < 4; i++) mw[i] = mwp[i];
        @(negedge clk_sys);
        chk("wp_flags", {60'd0, wp}, {60'd0, mw});
    endtask

    task automatic req(input bit op, input int d, input int t, input int s,
                       input logic [7:0] sl, output int cyc);
        int         lin, lba;
        bit         nf, hit;
        logic [1:0] e;
        lin = t * 10 + s;
        lba = lin / 2;
        m_half = lin % 2;
        salt = sl;
        nf  = (s >= 10) || (msize[d] == 0) || ((lin + 1) * 256 > msize[d]);
        hit = m_valid && (m_drv == d) && (m_lba == lba);
        if (nf) begin
            e = 2'd1;
        end else if (op && mwp[d]) begin
            e = 2'd2;
        end else if (!ack_en) begin
            e = 2'd3;
            if (!op || !hit) m_valid = 1'b0;
        end else begin
            if (!op || !hit) begin
                exp_sd.push_back('{1'b0, 2'(d), 32'(lba)});
                for (int i = 0; i < 512; i++)
                    if (!op || (i / 256) != m_half) m_buf[i] = 8'(i) ^ sl;
                m_valid = 1'b1;
                m_drv   = d;
                m_lba   = lba;
            end
            if (op) begin
                exp_sd.push_back('{1'b1, 2'(d), 32'(lba)});
                for (int i = 0; i < 512; i++) exp_wr.push_back(m_buf[i]);
            end
            e = 2'd0;
        end
        exp_err.push_back(e);
        @(posedge clk_sys);
        #1;
        sd_cnt = 0;
        drv    = 2'(d);
        track  = 7'(t);
        sector = 4'(s);
        rd_req = !op;
        wr_req = op;
        @(posedge clk_sys);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        wait_idle(2000, cyc);
    endtask

    task automatic fdc_wr(input int a, input logic [7:0] v);
        @(posedge clk_sys);
        #1;
        buf_addr = 8'(a);
        buf_din  = v;
        buf_we   = 1'b1;
        @(posedge clk_sys);
        #1;
        buf_we = 1'b0;
        m_buf[m_half * 256 + a] = v;
    endtask

    task automatic fdc_rd(input int a);
        @(posedge clk_sys);
        #1;
        buf_addr = 8'(a);
        fdc_rd_s = 1'b1;
        exp_rd.push_back(m_buf[m_half * 256 + a]);
        @(posedge clk_sys);
        #1;
        fdc_rd_s = 1'b0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc, n;
        m_valid = 1'b0;
        m_drv = 0;
        m_lba = 0;
        m_half = 0;
        for (int i = 0; i < 4; i++) begin
            msize[i] = 0;
            mwp[i] = 1'b0;
        end
        for (int i = 0; i < 512; i++) m_buf[i] = '0;

        #23;
        chk("reset_outs", {busy, done, err, wp, sd_rd, sd_wr, sd_lba[19:0]}, 64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        mount(0, 89600, 1'b0);
        req(1'b0, 0, 1, 3, 8'h00, cyc);
        fdc_rd(8'h00);
        fdc_rd(8'hFF);
        fdc_rd(8'h37);

        req(1'b0, 0, 34, 9, 8'($urandom), cyc);
        fdc_rd(8'h10);
        req(1'b0, 0, 35, 0, 8'h00, cyc);
        chk("rnf_cycles", 64'(cyc), 64'd2);
        chk("rnf_no_sd", 64'(sd_cnt), 64'd0);
        req(1'b0, 0, 0, 10, 8'h00, cyc);
        req(1'b0, 2, 0, 0, 8'h00, cyc);
        chk("unmounted_no_sd", 64'(sd_cnt), 64'd0);

        mount(1, 89600, 1'b1);
        req(1'b1, 1, 0, 0, 8'h00, cyc);
        chk("wp_no_sd", 64'(sd_cnt), 64'd0);

        req(1'b0, 0, 0, 4, 8'($urandom), cyc);
        fdc_wr(5, 8'hA5);
        fdc_rd(5);
        req(1'b1, 0, 0, 4, 8'($urandom), cyc);

        mount(3, 30 * 2560 + int'($urandom_range(0, 2559)), 1'b0);
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) == 0)
                fdc_wr(int'($urandom_range(0, 255)), 8'($urandom));
            req(1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 39)), int'($urandom_range(0, 11)),
                8'($urandom), cyc);
            fdc_rd(int'($urandom_range(0, 255)));
            fdc_rd(int'($urandom_range(0, 255)));
        end

        ack_en = 1'b0;
        req(1'b0, 0, 2, 0, 8'h00, cyc);
        chk("tmo_len_ok", {63'd0, (cyc >= int'(TMO)) && (cyc <= int'(TMO) + 5)}, 64'd1);
        chk("tmo_sd_rd_drop", {60'd0, sd_rd}, 64'd0);
        ack_en = 1'b1;

        exp_sd.push_back('{1'b0, 2'd0, 32'd3});
        salt = 8'h5A;
        @(posedge clk_sys);
        #1;
        drv = 2'd0;
        track = 7'd0;
        sector = 4'd7;
        rd_req = 1'b1;
        @(posedge clk_sys);
        #1;
        rd_req = 1'b0;
        n = 0;
        while (!sd_ack && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("rst_ack_seen", {63'd0, sd_ack}, 64'd1);
        repeat (100) @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_sd_rd", {56'd0, sd_rd, sd_wr}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        m_valid = 1'b0;
        m_drv = 0;
        m_half = 0;
        for (int i = 0; i < 4; i++) begin
            msize[i] = 0;
            mwp[i] = 1'b0;
        end
        mount(0, 89600, 1'b0);
        req(1'b0, 0, 5, 1, 8'hC3, cyc);
        fdc_rd(8'h00);
        fdc_rd(8'h80);

        repeat (5) @(negedge clk_sys);
        chk("pending_done", 64'(exp_err.size()), 64'd0);
        chk("pending_sd", 64'(exp_sd.size()), 64'd0);
        chk("pending_rd", 64'(exp_rd.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
